des_crypt_pipelined_param: RTL and testbench

- Parametrised, fully pipelined DES engine for encryption and decryption.
- Per-block mode bit, configurable number of rounds per pipeline stage, and a sideband tag carried with each block.
- Valid/ready backpressure, so it can sit between a message source FIFO and a result sink that may stall.
- Replaces the fixed 16-stage encrypt-only pipeline as the DES datapath in the key-search and bulk-crypt tops.

---
 rtl/des_pkg.sv | 85 ++++++++
 rtl/des_round.sv | 34 +++
 rtl/ip_inverse_permutation.sv | 13 +
 rtl/ip_permutation.sv | 13 +
 rtl/des_crypt_pipelined_param.sv | 131 +++++++++++++
 tb/tb_des_crypt_pipelined_param.sv | 372 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/des_pkg.sv
// Shared DES constants, permutation/substitution tables and key-slot selection.
// Table entries are 1-based DES bit numbers, matching the [1:N] vectors used throughout.
package des_pkg;

    localparam int unsigned DES_ROUNDS  = 16;
    localparam int unsigned DES_KEY_W   = 48;
    localparam int unsigned DES_BLOCK_W = 64;
    localparam int unsigned DES_HALF_W  = DES_BLOCK_W / 2;
    localparam int unsigned DES_KEYS_W  = DES_ROUNDS * DES_KEY_W;

    typedef struct packed {
        logic [1:DES_HALF_W] l;
        logic [1:DES_HALF_W] r;
    } des_lr_t;

    localparam int unsigned IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int unsigned IP_INV_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // Indexed by {b1, b6, b2..b5} of each 6-bit group.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // Start index in the [1:768] key bundle of the subkey used by a round.
    function automatic int unsigned des_key_sel(input int unsigned round, input logic decrypt);
        int unsigned x;
        x = decrypt ? (DES_ROUNDS + 1 - round) : round;
        return (x - 1) * DES_KEY_W + 1;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round
    import des_pkg::*;
(
    input  logic [1:DES_HALF_W] left,
    input  logic [1:DES_HALF_W] right,
    input  logic [1:DES_KEY_W]  key,
    output logic [1:DES_HALF_W] left_next_c,
    output logic [1:DES_HALF_W] right_next_c
);

    logic [1:DES_KEY_W]  expanded;
    logic [1:DES_HALF_W] substituted;
    logic [1:DES_HALF_W] f_out;

    for (genvar i = 1; i <= 48; i++) begin : g_expand
        assign expanded[i] = right[E_TBL[i-1]] ^ key[i];
    end

    // Outer bits select the row, inner four the column.
    for (genvar j = 0; j < 8; j++) begin : g_sbox
        logic [5:0] six;
        assign six = expanded[6*j+1 +: 6];
        assign substituted[4*j+1 +: 4] = SBOX[j][{six[5], six[0], six[4:1]}];
    end

    for (genvar i = 1; i <= 32; i++) begin : g_perm
        assign f_out[i] = substituted[P_TBL[i-1]];
    end

    assign left_next_c  = right;
    assign right_next_c = left ^ f_out;

endmodule

// File: rtl/ip_inverse_permutation.sv
// DES final permutation (IP^-1), pure wiring.
module ip_inverse_permutation
    import des_pkg::*;
(
    input  logic [1:DES_BLOCK_W] block,
    output logic [1:DES_BLOCK_W] permuted_c
);

    for (genvar i = 1; i <= 64; i++) begin : g_bit
        assign permuted_c[i] = block[IP_INV_TBL[i-1]];
    end

endmodule

// File: rtl/ip_permutation.sv
// DES initial permutation (IP), pure wiring.
module ip_permutation
    import des_pkg::*;
(
    input  logic [1:DES_BLOCK_W] block,
    output logic [1:DES_BLOCK_W] permuted_c
);

    for (genvar i = 1; i <= 64; i++) begin : g_bit
        assign permuted_c[i] = block[IP_TBL[i-1]];
    end

endmodule

// File: rtl/des_crypt_pipelined_param.sv
// Fully pipelined DES encrypt/decrypt engine with per-block mode, sideband tag and
// a single global stall enable driven by the output handshake.
module des_crypt_pipelined_param
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_STAGE = 1,
    parameter int unsigned TAG_W            = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic                  i_decrypt,
    input  logic [TAG_W-1:0]      i_tag,
    input  logic [1:DES_BLOCK_W]  message,
    input  logic [1:DES_KEYS_W]   round_keys,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_decrypt,
    output logic [TAG_W-1:0]      o_tag,
    output logic [1:DES_BLOCK_W]  result
);

    localparam int unsigned RPS = ROUNDS_PER_STAGE;
    localparam int unsigned S   = DES_ROUNDS / RPS;

    if (!(RPS == 1 || RPS == 2 || RPS == 4 || RPS == 8 || RPS == 16)) begin : g_bad_rps
        $error("ROUNDS_PER_STAGE must be 1, 2, 4, 8 or 16");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("TAG_W must be at least 1");
    end

    // Level 0 is the input register, levels 1..S are the round-stage registers.
    logic               valid_q [S+1];
    logic               dec_q   [S+1];
    logic [TAG_W-1:0]   tag_q   [S+1];
    des_lr_t            lr_q    [S+1];

    logic                 ce;
    logic [1:DES_BLOCK_W] ip_c;
    logic [1:DES_BLOCK_W] final_c;

    assign ce      = !(o_valid && !o_ready);
    assign i_ready = ce;

    ip_permutation u_ip (
        .block      (message),
        .permuted_c (ip_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q[0] <= 1'b0;
        end else if (ce) begin
            valid_q[0] <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            dec_q[0] <= i_decrypt;
            tag_q[0] <= i_tag;
            lr_q[0]  <= ip_c;
        end
    end

    for (genvar k = 1; k <= S; k++) begin : g_stage
        logic [1:DES_HALF_W] cl [RPS+1];
        logic [1:DES_HALF_W] cr [RPS+1];

        assign cl[0] = lr_q[k-1].l;
        assign cr[0] = lr_q[k-1].r;

        // Subkey chosen by this stage's own mode bit so modes can interleave freely.
        for (genvar j = 0; j < RPS; j++) begin : g_round
            localparam int unsigned RND     = (k - 1) * RPS + j + 1;
            localparam int unsigned ENC_OFF = des_key_sel(RND, 1'b0);
            localparam int unsigned DEC_OFF = des_key_sel(RND, 1'b1);
            logic [1:DES_KEY_W] key;

            assign key = dec_q[k-1] ? round_keys[DEC_OFF +: DES_KEY_W]
                                    : round_keys[ENC_OFF +: DES_KEY_W];

            des_round u_round (
                .left         (cl[j]),
                .right        (cr[j]),
                .key          (key),
                .left_next_c  (cl[j+1]),
                .right_next_c (cr[j+1])
            );
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q[k] <= 1'b0;
            end else if (ce) begin
                valid_q[k] <= valid_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (ce) begin
                dec_q[k] <= dec_q[k-1];
                tag_q[k] <= tag_q[k-1];
                lr_q[k]  <= {cl[RPS], cr[RPS]};
            end
        end
    end

    // Halves are swapped back after round 16 before the final permutation.
    ip_inverse_permutation u_ip_inv (
        .block      ({lr_q[S].r, lr_q[S].l}),
        .permuted_c (final_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            o_decrypt <= 1'b0;
            o_tag     <= '0;
            result    <= '0;
        end else if (ce) begin
            o_valid   <= valid_q[S];
            o_decrypt <= dec_q[S];
            o_tag     <= tag_q[S];
            result    <= final_c;
        end
    end

endmodule

// File: tb/tb_des_crypt_pipelined_param.sv
// Directed bench for the pipelined DES engine; five instances cover every legal stage depth.
module tb_des_crypt_pipelined_param;

    localparam int NDUT = 5;
    localparam int unsigned RPS_OF [NDUT] = '{1, 2, 4, 8, 16};
    localparam int STAGES [NDUT] = '{16, 8, 4, 2, 1};

    localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [1:64] PT_A  = 64'h0123456789ABCDEF;
    localparam logic [1:64] CT_A  = 64'h85E813540F0AB405;
    localparam logic [1:64] CT_Z  = 64'h8CA64DE9C1B123A7;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         i_decrypt;
    logic [7:0]   i_tag;
    logic [1:64]  message;
    logic [1:768] round_keys;
    logic         o_ready;

    logic         irdy [NDUT];
    logic         ov   [NDUT];
    logic         odec [NDUT];
    logic [7:0]   otag [NDUT];
    logic [1:64]  res  [NDUT];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        des_crypt_pipelined_param #(
            .ROUNDS_PER_STAGE (RPS_OF[g]),
            .TAG_W            (8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_valid    (i_valid),
            .i_ready    (irdy[g]),
            .i_decrypt  (i_decrypt),
            .i_tag      (i_tag),
            .message    (message),
            .round_keys (round_keys),
            .o_valid    (ov[g]),
            .o_ready    (o_ready),
            .o_decrypt  (odec[g]),
            .o_tag      (otag[g]),
            .result     (res[g])
        );
    end

    function automatic logic [1:768] key_sched(input logic [1:64] key);
        logic [1:56]  cd;
        logic [1:28]  c;
        logic [1:28]  d;
        logic [1:768] ks;
        ks = '0;
        for (int i = 0; i < 56; i++) cd[i+1] = key[PC1[i]];
        c = cd[1:28];
        d = cd[29:56];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[2:28], c[1]};
                d = {d[2:28], d[1]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[r*48+i+1] = cd[PC2[i]];
        end
        return ks;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick();
        tick();
        for (int g = 0; g < NDUT; g++) begin
            vectors++;
            if (ov[g] !== 1'b0 || res[g] !== 64'h0 || otag[g] !== 8'h00 || odec[g] !== 1'b0 || irdy[g] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset dut%0d: got v=%b r=%h t=%h d=%b rdy=%b want v=0 r=0 t=0 d=0 rdy=1",
                         g, ov[g], res[g], otag[g], odec[g], irdy[g]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt();
        do_reset();
        round_keys = key_sched(KEY_A);
        message = PT_A; i_decrypt = 1'b0; i_tag = 8'h5A; i_valid = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            i_valid = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                vectors++;
                if (ov[g] !== (t == STAGES[g] + 2)) begin
                    miscompares++;
                    $display("FAIL enc_valid dut%0d cycle %0d: got %b want %b", g, t, ov[g], (t == STAGES[g] + 2));
                end
                if (t == STAGES[g] + 2) begin
                    vectors++;
                    if (res[g] !== CT_A || otag[g] !== 8'h5A || odec[g] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL enc_result dut%0d: got %h tag %h dec %b want %h tag 5a dec 0", g, res[g], otag[g], odec[g], CT_A);
                    end
                end
            end
        end
    endtask

    task automatic test_decrypt();
        do_reset();
        round_keys = key_sched(KEY_A);
        message = CT_A; i_decrypt = 1'b1; i_tag = 8'hA7; i_valid = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            i_valid = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                if (t == STAGES[g] + 2) begin
                    vectors++;
                    if (ov[g] !== 1'b1 || res[g] !== PT_A || otag[g] !== 8'hA7 || odec[g] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL dec_result dut%0d: got v=%b %h tag %h dec %b want v=1 %h tag a7 dec 1",
                                 g, ov[g], res[g], otag[g], odec[g], PT_A);
                    end
                end
            end
        end
    endtask

    task automatic test_interleave();
        do_reset();
        round_keys = key_sched(64'h0);
        for (int t = 1; t <= 56; t++) begin
            if (t <= 32) begin
                int idx;
                idx = t - 1;
                i_valid   = 1'b1;
                i_decrypt = idx[0];
                message   = idx[0] ? CT_Z : 64'h0;
                i_tag     = 8'(idx);
            end else begin
                i_valid = 1'b0;
            end
            tick();
            for (int g = 0; g < NDUT; g++) begin
                int e;
                logic exp_v;
                logic [1:64] exp_res;
                e = t - (STAGES[g] + 2);
                exp_v = (e >= 0 && e < 32);
                exp_res = e[0] ? 64'h0 : CT_Z;
                vectors++;
                if (ov[g] !== exp_v) begin
                    miscompares++;
                    $display("FAIL mix_valid dut%0d cycle %0d: got %b want %b", g, t, ov[g], exp_v);
                end
                if (exp_v) begin
                    vectors++;
                    if (res[g] !== exp_res || otag[g] !== 8'(e) || odec[g] !== e[0]) begin
                        miscompares++;
                        $display("FAIL mix_block dut%0d #%0d: got %h tag %h dec %b want %h tag %h dec %b",
                                 g, e, res[g], otag[g], odec[g], exp_res, 8'(e), e[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int src;
        int snk;
        logic [1:64] held_res;
        logic [7:0]  held_tag;
        logic [1:64] exp_res;
        do_reset();
        round_keys = key_sched(64'h0);
        src = 0;
        snk = 0;
        held_res = '0;
        held_tag = '0;
        for (int it = 0; it < 120 && snk < 30; it++) begin
            o_ready = !(it >= 20 && it < 25);
            if (src < 30) begin
                i_valid   = 1'b1;
                i_decrypt = src[0];
                message   = src[0] ? CT_Z : 64'h0;
                i_tag     = 8'(8'h40 + src);
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (it == 20) begin
                held_res = res[0];
                held_tag = otag[0];
            end
            if (it >= 20 && it < 25) begin
                vectors++;
                if (irdy[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_ready cycle %0d: got %b want 0", it, irdy[0]);
                end
            end
            if (it >= 21 && it <= 25) begin
                vectors++;
                if (ov[0] !== 1'b1 || res[0] !== held_res || otag[0] !== held_tag) begin
                    miscompares++;
                    $display("FAIL stall_hold cycle %0d: got v=%b %h tag %h want v=1 %h tag %h",
                             it, ov[0], res[0], otag[0], held_res, held_tag);
                end
            end
            if (ov[0]) begin
                exp_res = snk[0] ? 64'h0 : CT_Z;
                vectors++;
                if (res[0] !== exp_res || otag[0] !== 8'(8'h40 + snk)) begin
                    miscompares++;
                    $display("FAIL bp_order #%0d: got %h tag %h want %h tag %h", snk, res[0], otag[0], exp_res, 8'(8'h40 + snk));
                end
                if (o_ready) snk++;
            end
            if (i_valid && irdy[0]) src++;
            tick();
        end
        vectors++;
        if (snk !== 30) begin
            miscompares++;
            $display("FAIL bp_count: got %0d blocks want 30", snk);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            vectors++;
            if (ov[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_extra cycle %0d: got o_valid %b want 0", t, ov[0]);
            end
            tick();
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        round_keys = key_sched(KEY_A);
        o_ready = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            i_valid   = (t == 1 || t == 4 || t == 5);
            i_decrypt = 1'b0;
            message   = PT_A;
            i_tag     = 8'(t - 1);
            tick();
            for (int g = 0; g < NDUT; g++) begin
                logic exp_v;
                exp_v = (t == STAGES[g] + 2 || t == STAGES[g] + 5 || t == STAGES[g] + 6);
                vectors++;
                if (ov[g] !== exp_v) begin
                    miscompares++;
                    $display("FAIL bubble_valid dut%0d cycle %0d: got %b want %b", g, t, ov[g], exp_v);
                end
                if (exp_v) begin
                    vectors++;
                    if (res[g] !== CT_A || otag[g] !== 8'(t - STAGES[g] - 2)) begin
                        miscompares++;
                        $display("FAIL bubble_block dut%0d cycle %0d: got %h tag %h want %h tag %h",
                                 g, t, res[g], otag[g], CT_A, 8'(t - STAGES[g] - 2));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        round_keys = key_sched(64'h0);
        o_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_decrypt = 1'b0; message = 64'h0; i_tag = 8'(i);
            tick();
        end
        i_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        for (int g = 0; g < NDUT; g++) begin
            vectors++;
            if (ov[g] !== 1'b0 || res[g] !== 64'h0) begin
                miscompares++;
                $display("FAIL midrst_clear dut%0d: got v=%b %h want v=0 0", g, ov[g], res[g]);
            end
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                vectors++;
                if (ov[g] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrst_stale dut%0d cycle %0d: got o_valid %b want 0", g, t, ov[g]);
                end
            end
        end
        i_valid = 1'b1; i_decrypt = 1'b0; message = 64'h0; i_tag = 8'hC3;
        for (int t = 1; t <= 20; t++) begin
            tick();
            i_valid = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                vectors++;
                if (ov[g] !== (t == STAGES[g] + 2)) begin
                    miscompares++;
                    $display("FAIL midrst_new_valid dut%0d cycle %0d: got %b want %b", g, t, ov[g], (t == STAGES[g] + 2));
                end
                if (t == STAGES[g] + 2) begin
                    vectors++;
                    if (res[g] !== CT_Z || otag[g] !== 8'hC3) begin
                        miscompares++;
                        $display("FAIL midrst_new_block dut%0d: got %h tag %h want %h tag c3", g, res[g], otag[g], CT_Z);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_decrypt  = 1'b0;
        i_tag      = '0;
        message    = '0;
        round_keys = '0;
        o_ready    = 1'b1;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_interleave();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
